butterfly_pipe: RTL and testbench

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

---
 rtl/butterfly_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_butterfly_pipe.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_pipe.sv
// -----------------------------------------------------------------------------
// butterfly_pipe
//   Three-stage pipelined radix-2 complex butterfly with fixed-point
//   saturation, optional divide-by-2 output scaling and a sticky overflow flag.
//   Complex words are packed {real, imag}, each half a signed two's-complement
//   value with FRAC_BITS fractional bits.
//
//   DIT: o_A = A + B*W,  o_B = A - B*W
//   DIF: o_A = A + B,    o_B = (A - B)*W
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid / o_ready    input handshake (transfer when both are high)
//   i_A, i_B, i_twiddle  operands and twiddle factor W
//   i_mode               0 = DIT, 1 = DIF (captured with the sample)
//   i_scale              1 = halve both results (captured with the sample)
//   o_valid / i_ready    output handshake
//   o_A, o_B             results, held while no new result is presented
//   o_ovf, i_ovf_clr     sticky saturation flag and its synchronous clear
// -----------------------------------------------------------------------------
module butterfly_pipe #(
    parameter int WORD_SZ   = 32,
    parameter int FRAC_BITS = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WORD_SZ-1:0] i_A,
    input  logic [WORD_SZ-1:0] i_B,
    input  logic [WORD_SZ-1:0] i_twiddle,
    input  logic               i_mode,
    input  logic               i_scale,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WORD_SZ-1:0] o_A,
    output logic [WORD_SZ-1:0] o_B,
    output logic               o_ovf,
    input  logic               i_ovf_clr
);
    localparam int WORD_MID = WORD_SZ / 2;
    // Product sum width plus one guard bit so the rounding add cannot wrap.
    localparam int PW = 2 * WORD_MID + 2;
    localparam logic [WORD_MID-1:0] MAX_V = {1'b0, {(WORD_MID-1){1'b1}}};
    localparam logic [WORD_MID-1:0] MIN_V = {1'b1, {(WORD_MID-1){1'b0}}};
    localparam logic [PW-1:0] ROUND_K = (FRAC_BITS > 0) ? (PW'(1) << (FRAC_BITS - 1)) : '0;

    // Sign-extend a half-word by one bit.
    function automatic logic [WORD_MID:0] sx(input logic [WORD_MID-1:0] v);
        return {v[WORD_MID-1], v};
    endfunction

    // One-guard-bit value leaves the half-word range when the top two bits differ.
    function automatic logic clips_n(input logic [WORD_MID:0] v);
        return v[WORD_MID] ^ v[WORD_MID-1];
    endfunction

    function automatic logic [WORD_MID-1:0] sat_n(input logic [WORD_MID:0] v);
        if (clips_n(v)) return v[WORD_MID] ? MIN_V : MAX_V;
        return v[WORD_MID-1:0];
    endfunction

    // Wide value fits a half-word only if all bits above the half-word sign agree.
    function automatic logic clips_p(input logic [PW-1:0] v);
        return !((&v[PW-1:WORD_MID-1]) || !(|v[PW-1:WORD_MID-1]));
    endfunction

    function automatic logic [WORD_MID-1:0] sat_p(input logic [PW-1:0] v);
        if (clips_p(v)) return v[PW-1] ? MIN_V : MAX_V;
        return v[WORD_MID-1:0];
    endfunction

    logic stall;
    logic sat_event;

    // Stage registers
    logic               s1_valid, s1_mode, s1_scale;
    logic [WORD_SZ-1:0] s1_a, s1_x, s1_w;
    logic               s2_valid, s2_mode, s2_scale;
    logic [WORD_SZ-1:0] s2_a, s2_p;
    logic               s3_valid;
    logic [WORD_SZ-1:0] s3_a, s3_b;
    logic               ovf_flag;

    // ---------------- S1: DIF pre-add/subtract ----------------
    logic [WORD_SZ-1:0] s1_a_next, s1_x_next;
    logic [1:0]         s1_clip;

    for (genvar gi = 0; gi < 2; gi++) begin : g_s1
        logic [WORD_MID-1:0] a_h, b_h;
        logic [WORD_MID:0]   sum_w, dif_w;
        assign a_h   = i_A[gi*WORD_MID +: WORD_MID];
        assign b_h   = i_B[gi*WORD_MID +: WORD_MID];
        assign sum_w = sx(a_h) + sx(b_h);
        assign dif_w = sx(a_h) - sx(b_h);
        assign s1_a_next[gi*WORD_MID +: WORD_MID] = i_mode ? sat_n(sum_w) : a_h;
        assign s1_x_next[gi*WORD_MID +: WORD_MID] = i_mode ? sat_n(dif_w) : b_h;
        assign s1_clip[gi] = i_mode && (clips_n(sum_w) || clips_n(dif_w));
    end

    // ---------------- S2: complex multiply X*W ----------------
    // Operands are extended to 2*WORD_MID bits so each product is exact.
    logic [2*WORD_MID-1:0] xr, xi, wr, wi;
    logic [2*WORD_MID-1:0] m_rr, m_ii, m_ri, m_ir;
    logic [PW-1:0]         pr_full, pi_full, pr_rnd, pi_rnd, pr_sh, pi_sh;
    logic [WORD_SZ-1:0]    s2_p_next;
    logic                  s2_clip;

    assign xr = {{WORD_MID{s1_x[WORD_SZ-1]}},  s1_x[WORD_SZ-1:WORD_MID]};
    assign xi = {{WORD_MID{s1_x[WORD_MID-1]}}, s1_x[WORD_MID-1:0]};
    assign wr = {{WORD_MID{s1_w[WORD_SZ-1]}},  s1_w[WORD_SZ-1:WORD_MID]};
    assign wi = {{WORD_MID{s1_w[WORD_MID-1]}}, s1_w[WORD_MID-1:0]};

    assign m_rr = $signed(xr) * $signed(wr);
    assign m_ii = $signed(xi) * $signed(wi);
    assign m_ri = $signed(xr) * $signed(wi);
    assign m_ir = $signed(xi) * $signed(wr);

    assign pr_full = {{2{m_rr[2*WORD_MID-1]}}, m_rr} - {{2{m_ii[2*WORD_MID-1]}}, m_ii};
    assign pi_full = {{2{m_ri[2*WORD_MID-1]}}, m_ri} + {{2{m_ir[2*WORD_MID-1]}}, m_ir};

    // Round half-up: add half an LSB, then arithmetic shift.
    assign pr_rnd = pr_full + ROUND_K;
    assign pi_rnd = pi_full + ROUND_K;
    assign pr_sh  = $signed(pr_rnd) >>> FRAC_BITS;
    assign pi_sh  = $signed(pi_rnd) >>> FRAC_BITS;

    assign s2_p_next = {sat_p(pr_sh), sat_p(pi_sh)};
    assign s2_clip   = clips_p(pr_sh) || clips_p(pi_sh);

    // ---------------- S3: post add/subtract and scaling ----------------
    logic [WORD_SZ-1:0] s3_a_next, s3_b_next;
    logic [1:0]         s3_clip;

    for (genvar gi = 0; gi < 2; gi++) begin : g_s3
        logic [WORD_MID-1:0] a_h, p_h;
        logic [WORD_MID:0]   ra, rb;
        assign a_h = s2_a[gi*WORD_MID +: WORD_MID];
        assign p_h = s2_p[gi*WORD_MID +: WORD_MID];
        assign ra  = s2_mode ? sx(a_h) : (sx(a_h) + sx(p_h));
        assign rb  = s2_mode ? sx(p_h) : (sx(a_h) - sx(p_h));
        // Scaling keeps the guard bit and drops the LSB (floor divide by 2).
        assign s3_a_next[gi*WORD_MID +: WORD_MID] = s2_scale ? ra[WORD_MID:1] : sat_n(ra);
        assign s3_b_next[gi*WORD_MID +: WORD_MID] = s2_scale ? rb[WORD_MID:1] : sat_n(rb);
        assign s3_clip[gi] = !s2_scale && (clips_n(ra) || clips_n(rb));
    end

    // ---------------- Control ----------------
    // A full output that is not taken freezes the whole pipe.
    assign stall   = s3_valid && !i_ready;
    assign o_ready = !stall;

    // Only stages that actually advance a valid sample may flag saturation.
    assign sat_event = !stall && ((i_valid && (|s1_clip)) ||
                                  (s1_valid && s2_clip) ||
                                  (s2_valid && (|s3_clip)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_scale <= 1'b0;
            s1_a     <= '0;
            s1_x     <= '0;
            s1_w     <= '0;
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_scale <= 1'b0;
            s2_a     <= '0;
            s2_p     <= '0;
            s3_valid <= 1'b0;
            s3_a     <= '0;
            s3_b     <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (!stall) begin
                s1_valid <= i_valid;
                if (i_valid) begin
                    s1_mode  <= i_mode;
                    s1_scale <= i_scale;
                    s1_a     <= s1_a_next;
                    s1_x     <= s1_x_next;
                    s1_w     <= i_twiddle;
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_mode  <= s1_mode;
                    s2_scale <= s1_scale;
                    s2_a     <= s1_a;
                    s2_p     <= s2_p_next;
                end
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    s3_a <= s3_a_next;
                    s3_b <= s3_b_next;
                end
            end
            // A new saturation wins over a simultaneous clear.
            ovf_flag <= (ovf_flag && !i_ovf_clr) || sat_event;
        end
    end

    assign o_valid = s3_valid;
    assign o_A     = s3_a;
    assign o_B     = s3_b;
    assign o_ovf   = ovf_flag;

endmodule

// File: tb/tb_butterfly_pipe.sv
`timescale 1ns/1ps
module tb_butterfly_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_A, i_B, i_twiddle;
    logic        i_mode, i_scale;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_A, o_B;
    logic        o_ovf;
    logic        i_ovf_clr;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] a, b, w;
        logic        mode, scale;
        logic [63:0] exp;
        logic        clip;
    } vec_t;

    butterfly_pipe #(.WORD_SZ(32), .FRAC_BITS(6)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_A      (i_A),
        .i_B      (i_B),
        .i_twiddle(i_twiddle),
        .i_mode   (i_mode),
        .i_scale  (i_scale),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_A      (o_A),
        .o_B      (o_B),
        .o_ovf    (o_ovf),
        .i_ovf_clr(i_ovf_clr)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model (integer arithmetic) ----------------
    function automatic longint clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic bit out16(input longint v);
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic logic [64:0] model(input logic [31:0] a, b, w, input logic mode, scale);
        longint ar, ai, br, bi, wr, wi, xr, xi, pr, pi, ra_r, ra_i, rb_r, rb_i;
        bit clip;
        clip = 1'b0;
        ar = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
        wr = longint'($signed(w[31:16])); wi = longint'($signed(w[15:0]));
        if (mode) begin
            clip = out16(ar + br) || out16(ai + bi) || out16(ar - br) || out16(ai - bi);
            xr = clamp16(ar - br); xi = clamp16(ai - bi);
            ar = clamp16(ar + br); ai = clamp16(ai + bi);
        end else begin
            xr = br; xi = bi;
        end
        pr = (xr * wr - xi * wi + 32) >>> 6;
        pi = (xr * wi + xi * wr + 32) >>> 6;
        clip = clip || out16(pr) || out16(pi);
        pr = clamp16(pr); pi = clamp16(pi);
        if (mode) begin
            ra_r = ar; ra_i = ai; rb_r = pr; rb_i = pi;
        end else begin
            ra_r = ar + pr; ra_i = ai + pi; rb_r = ar - pr; rb_i = ai - pi;
        end
        if (scale) begin
            ra_r = ra_r >>> 1; ra_i = ra_i >>> 1; rb_r = rb_r >>> 1; rb_i = rb_i >>> 1;
        end else begin
            clip = clip || out16(ra_r) || out16(ra_i) || out16(rb_r) || out16(rb_i);
            ra_r = clamp16(ra_r); ra_i = clamp16(ra_i);
            rb_r = clamp16(rb_r); rb_i = clamp16(rb_i);
        end
        return {clip, 16'(ra_r), 16'(ra_i), 16'(rb_r), 16'(rb_i)};
    endfunction

    function automatic logic [15:0] rnd_half(input bit big);
        if (big) return 16'($urandom);
        return 16'($urandom_range(0, 1023) - 32'd512);
    endfunction

    function automatic vec_t rand_vec(input bit allow_big);
        vec_t v;
        logic [64:0] m;
        bit big;
        big = allow_big && ($urandom_range(0, 2) == 0);
        v.a = {rnd_half(big), rnd_half(big)};
        v.b = {rnd_half(big), rnd_half(big)};
        v.w = {rnd_half(big), rnd_half(big)};
        v.mode  = 1'($urandom_range(0, 1));
        v.scale = 1'($urandom_range(0, 1));
        m = model(v.a, v.b, v.w, v.mode, v.scale);
        v.exp  = m[63:0];
        v.clip = m[64];
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic valid);
        i_valid   = valid;
        i_A       = v.a;
        i_B       = v.b;
        i_twiddle = v.w;
        i_mode    = v.mode;
        i_scale   = v.scale;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_ovf_clr = 1'b0;
        i_A = '0; i_B = '0; i_twiddle = '0; i_mode = 1'b0; i_scale = 1'b0;
        #2;
        checks++;
        if (o_valid !== 1'b0 || o_ovf !== 1'b0 || o_A !== 32'h0 || o_B !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ovf=%b A=%h B=%h, need all 0", o_valid, o_ovf, o_A, o_B);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, need 1", o_ready);
        end
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got valid=%b ready=%b, need 0/1", o_valid, o_ready);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_directed();
        vec_t tv[6];
        int idx = 0;
        logic [63:0] e;
        logic [63:0] last = '0;
        tv[0] = '{32'h00400080, 32'h00C00100, 32'h00400000, 1'b0, 1'b0, 64'h01000180_FF80FF80, 1'b0};
        tv[1] = '{32'h00400080, 32'h00C00100, 32'h00000040, 1'b0, 1'b0, 64'hFF400140_0140FFC0, 1'b0};
        tv[2] = '{32'h00400080, 32'h00C00100, 32'h00000040, 1'b0, 1'b1, 64'hFFA000A0_00A0FFE0, 1'b0};
        tv[3] = '{32'h00400080, 32'h00C00100, 32'h00400000, 1'b1, 1'b0, 64'h01000180_FF80FF80, 1'b0};
        tv[4] = '{32'h00400080, 32'h00C00100, 32'h00400000, 1'b1, 1'b1, 64'h008000C0_FFC0FFC0, 1'b0};
        tv[5] = '{32'h00400080, 32'h00C00100, 32'h00000040, 1'b1, 1'b0, 64'h01000180_0080FF80, 1'b0};
        i_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            drive(tv[idx < 6 ? idx : 5], idx < 6);
            #1;
            if (o_valid && i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL directed_extra: unexpected A=%h B=%h", o_A, o_B);
                end else begin
                    e = exp_q.pop_front();
                    last = e;
                    $display("directed out A=%h B=%h", o_A, o_B);
                    if ({o_A, o_B} !== e) begin
                        errors++;
                        $display("FAIL directed: got A=%h B=%h, need A=%h B=%h", o_A, o_B, e[63:32], e[31:0]);
                    end
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(tv[idx].exp);
                idx++;
            end
            @(posedge i_clk); #1;
        end
        checks++;
        if (exp_q.size() != 0 || idx != 6) begin
            errors++;
            $display("FAIL directed_drain: %0d outputs missing, %0d sent, need 0 and 6", exp_q.size(), idx);
        end
        exp_q.delete();
        checks++;
        if (o_valid !== 1'b0 || {o_A, o_B} !== last) begin
            errors++;
            $display("FAIL hold: got valid=%b A=%h B=%h, need 0 %h %h", o_valid, o_A, o_B, last[63:32], last[31:0]);
        end
        checks++;
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL directed_ovf: got %b, need 0", o_ovf);
        end
    endtask

    task automatic test_saturation();
        vec_t v = '{32'h7FFF0000, 32'h7FFF0000, 32'h00400000, 1'b0, 1'b0, 64'h7FFF0000_00000000, 1'b1};
        bit seen = 1'b0;
        i_ready = 1'b1;
        drive(v, 1'b1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            if (o_valid) begin
                seen = 1'b1;
                checks++;
                $display("sat out A=%h B=%h ovf=%b", o_A, o_B, o_ovf);
                if ({o_A, o_B} !== v.exp || o_ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL saturate: got A=%h B=%h ovf=%b, need 7fff0000 00000000 1", o_A, o_B, o_ovf);
                end
            end
            @(posedge i_clk); #1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL saturate_timeout: got no output, need one");
        end
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: got %b, need 1", o_ovf);
        end
        i_ovf_clr = 1'b1;
        @(posedge i_clk); #1;
        i_ovf_clr = 1'b0;
        checks++;
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cleared: got %b, need 0", o_ovf);
        end
        // Clear held high while the same saturating sample passes: set must win.
        i_ovf_clr = 1'b1;
        drive(v, 1'b1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            if (o_valid) begin
                seen = 1'b1;
                checks++;
                if (o_ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_clr_and_set: got %b, need 1", o_ovf);
                end
            end else begin
                @(posedge i_clk); #1;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL clr_set_timeout: got no output, need one");
        end
        @(posedge i_clk); #1;
        i_ovf_clr = 1'b0;
        checks++;
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr_after: got %b, need 0", o_ovf);
        end
    endtask

    task automatic test_back_to_back();
        vec_t tv[6];
        int idx = 0;
        int got = 0;
        logic [63:0] e;
        for (int k = 0; k < 6; k++) tv[k] = rand_vec(1'b0);
        for (int c = 1; c <= 20; c++) begin
            i_ready = !(c >= 4 && c <= 6);
            drive(tv[idx < 6 ? idx : 5], idx < 6);
            #1;
            checks++;
            if (o_ready !== !(o_valid && !i_ready)) begin
                errors++;
                $display("FAIL b2b_ready c=%0d: got %b with valid=%b ready_in=%b", c, o_ready, o_valid, i_ready);
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (o_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_stall_valid c=%0d: got %b, need 1", c, o_valid);
                end
            end
            if (o_valid && i_ready) begin
                checks++;
                got++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: unexpected A=%h B=%h", o_A, o_B);
                end else begin
                    e = exp_q.pop_front();
                    $display("b2b out %0d A=%h B=%h", got, o_A, o_B);
                    if ({o_A, o_B} !== e) begin
                        errors++;
                        $display("FAIL b2b: got A=%h B=%h, need A=%h B=%h", o_A, o_B, e[63:32], e[31:0]);
                    end
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(tv[idx].exp);
                idx++;
            end
            @(posedge i_clk); #1;
        end
        checks++;
        if (got != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs, need 6", got);
        end
        exp_q.delete();
        i_ready = 1'b1;
    endtask

    task automatic test_random();
        vec_t tv[24];
        int idx = 0;
        bit any_clip = 1'b0;
        logic [63:0] e;
        for (int k = 0; k < 24; k++) tv[k] = rand_vec(1'b1);
        i_ovf_clr = 1'b1;
        @(posedge i_clk); #1;
        i_ovf_clr = 1'b0;
        for (int c = 0; c < 400 && (idx < 24 || exp_q.size() != 0); c++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            drive(tv[idx < 24 ? idx : 23], (idx < 24) && ($urandom_range(0, 4) != 0));
            #1;
            if (o_valid && i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL random_extra: unexpected A=%h B=%h", o_A, o_B);
                end else begin
                    e = exp_q.pop_front();
                    $display("random out A=%h B=%h", o_A, o_B);
                    if ({o_A, o_B} !== e) begin
                        errors++;
                        $display("FAIL random: got A=%h B=%h, need A=%h B=%h", o_A, o_B, e[63:32], e[31:0]);
                    end
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(tv[idx].exp);
                any_clip = any_clip || tv[idx].clip;
                idx++;
            end
            @(posedge i_clk); #1;
        end
        checks++;
        if (idx != 24 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_timeout: sent %0d of 24, %0d pending", idx, exp_q.size());
        end
        exp_q.delete();
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_ovf !== any_clip) begin
            errors++;
            $display("FAIL random_ovf: got %b, need %b", o_ovf, any_clip);
        end
    endtask

    task automatic test_reset_in_flight();
        vec_t sat = '{32'h7FFF0000, 32'h7FFF0000, 32'h00400000, 1'b0, 1'b0, 64'h7FFF0000_00000000, 1'b1};
        vec_t v;
        i_ready = 1'b1;
        drive(sat, 1'b1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            v = rand_vec(1'b0);
            drive(v, 1'b1);
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_A !== 32'h0 || o_B !== 32'h0 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flight: got valid=%b A=%h B=%h ovf=%b, need all 0", o_valid, o_A, o_B, o_ovf);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flight_ready: got %b, need 1", o_ready);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_stale c=%0d: got valid=%b A=%h, need 0", c, o_valid, o_A);
            end
            @(posedge i_clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_in_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
